// File: rtl/reflet_uart_boot_sequencer.sv
// Power-up loader: receives a length-prefixed byte stream, packs bytes little-endian
// into RAM words written from address 0, then releases the CPU.
module reflet_uart_boot_sequencer #(
  parameter int unsigned wordsize       = 16,
  parameter int unsigned addr_width     = 10,
  parameter int unsigned timeout_cycles = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  reboot,
  output logic [addr_width-1:0] mem_addr,
  output logic [wordsize-1:0]   mem_wdata,
  output logic                  mem_we,
  output logic                  cpu_run,
  output logic                  busy,
  output logic                  error
);

  localparam int unsigned bpw       = wordsize / 8;
  localparam int unsigned max_bytes = (1 << addr_width) * bpw;
  localparam int unsigned tmo_w     = $clog2(timeout_cycles + 1);

  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, FLUSH, RUN} state_t;

  state_t                state, state_n;
  logic [15:0]           len, len_n;
  logic [15:0]           byte_cnt, byte_cnt_n;
  logic [addr_width-1:0] word_addr, word_addr_n, mem_addr_n;
  logic [wordsize-1:0]   pack, pack_n, pack_word, mem_wdata_n;
  logic [2:0]            lane, lane_n;
  logic [tmo_w-1:0]      tmo_cnt, tmo_n;
  logic                  error_n, mem_we_n;
  logic                  word_full, last_byte, tmo_expire;
  logic [15:0]           len_hdr;

  assign word_full  = (lane == 3'(bpw - 1));
  assign last_byte  = ((byte_cnt + 16'd1) == len);
  // Expiry cycle is the timeout_cycles-th idle clock; a byte arriving then wins.
  assign tmo_expire = !rx_valid && (tmo_cnt == tmo_w'(timeout_cycles - 1));
  assign len_hdr    = {rx_data, len[7:0]};

  // The final word's write is still in flight on the first RUN cycle.
  assign cpu_run = (state == RUN) && !mem_we;
  assign busy    = (state == LEN_HI) || (state == DATA) || (state == FLUSH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LEN_LO;
      len       <= '0;
      byte_cnt  <= '0;
      word_addr <= '0;
      pack      <= '0;
      lane      <= '0;
      tmo_cnt   <= '0;
      error     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      len       <= len_n;
      byte_cnt  <= byte_cnt_n;
      word_addr <= word_addr_n;
      pack      <= pack_n;
      lane      <= lane_n;
      tmo_cnt   <= tmo_n;
      error     <= error_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
    end
  end

  always_comb begin
    state_n     = state;
    len_n       = len;
    byte_cnt_n  = byte_cnt;
    word_addr_n = word_addr;
    pack_n      = pack;
    lane_n      = lane;
    tmo_n       = tmo_cnt;
    error_n     = error;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;

    pack_word = pack;
    for (int unsigned i = 0; i < bpw; i++) begin
      if (lane == 3'(i)) pack_word[8*i +: 8] = rx_data;
    end

    case (state)
      LEN_LO: begin
        byte_cnt_n  = '0;
        word_addr_n = '0;
        pack_n      = '0;
        lane_n      = '0;
        tmo_n       = '0;
        if (rx_valid) begin
          len_n[7:0] = rx_data;
          state_n    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          tmo_n       = '0;
          len_n[15:8] = rx_data;
          if (len_hdr == 16'd0) begin
            state_n = RUN;
            error_n = 1'b0;
          end else if (32'(len_hdr) > max_bytes) begin
            state_n = LEN_LO;
            error_n = 1'b1;
          end else begin
            state_n = DATA;
          end
        end else if (tmo_expire) begin
          state_n = LEN_LO;
          error_n = 1'b1;
          tmo_n   = '0;
        end else begin
          tmo_n = tmo_cnt + 1'b1;
        end
      end
      DATA: begin
        if (rx_valid) begin
          tmo_n      = '0;
          byte_cnt_n = byte_cnt + 16'd1;
          // A partial final word is issued now so it lands during the FLUSH cycle.
          if (word_full || last_byte) begin
            mem_we_n    = 1'b1;
            mem_addr_n  = word_addr;
            mem_wdata_n = pack_word;
            pack_n      = '0;
            lane_n      = '0;
            word_addr_n = word_addr + 1'b1;
          end else begin
            pack_n = pack_word;
            lane_n = lane + 3'd1;
          end
          if (last_byte) begin
            if (word_full) begin
              state_n = RUN;
              error_n = 1'b0;
            end else begin
              state_n = FLUSH;
            end
          end
        end else if (tmo_expire) begin
          state_n     = LEN_LO;
          error_n     = 1'b1;
          tmo_n       = '0;
          byte_cnt_n  = '0;
          word_addr_n = '0;
          pack_n      = '0;
          lane_n      = '0;
        end else begin
          tmo_n = tmo_cnt + 1'b1;
        end
      end
      FLUSH: begin
        state_n = RUN;
        error_n = 1'b0;
      end
      RUN: begin
        if (reboot) begin
          state_n     = LEN_LO;
          byte_cnt_n  = '0;
          word_addr_n = '0;
          pack_n      = '0;
          lane_n      = '0;
          tmo_n       = '0;
        end
      end
      default: state_n = LEN_LO;
    endcase
  end

endmodule

// File: tb/tb_reflet_uart_boot_sequencer.sv
// Bench for reflet_uart_boot_sequencer: table of load streams plus timing sequences;
// RAM writes are checked against a queue of expected {addr, data}.
module tb_reflet_uart_boot_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        reboot;
  logic [1:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we, cpu_run, busy, error;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0]  addr;
    logic [15:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct packed {
    logic [3:0]  n;
    logic [79:0] bytes;
    logic [2:0]  nw;
    logic [63:0] words;
    logic        run;
    logic        err;
  } vec_t;
  vec_t vecs [9];

  reflet_uart_boot_sequencer #(
    .wordsize(16),
    .addr_width(2),
    .timeout_cycles(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .reboot(reboot),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .cpu_run(cpu_run),
    .busy(busy),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {46'd0, mem_addr, mem_wdata}, 64'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(w.addr));
        check("wr_data", 64'(mem_wdata), 64'(w.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic expect_wr(input logic [1:0] a, input logic [15:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic do_reboot();
    reboot = 1'b1;
    tick();
    reboot = 1'b0;
    check("reboot_cpu_run_low", 64'(cpu_run), 64'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{n: 4'd6,  bytes: 80'h04030201_0004,          nw: 3'd2, words: 64'h0403_0201,           run: 1'b1, err: 1'b0};
    vecs[1] = '{n: 4'd5,  bytes: 80'hCCBBAA_0003,            nw: 3'd2, words: 64'h00CC_BBAA,           run: 1'b1, err: 1'b0};
    vecs[2] = '{n: 4'd2,  bytes: 80'h0000,                   nw: 3'd0, words: 64'h0,                   run: 1'b1, err: 1'b0};
    vecs[3] = '{n: 4'd2,  bytes: 80'h0009,                   nw: 3'd0, words: 64'h0,                   run: 1'b0, err: 1'b1};
    vecs[4] = '{n: 4'd4,  bytes: 80'h2211_0002,              nw: 3'd1, words: 64'h2211,                run: 1'b1, err: 1'b0};
    vecs[5] = '{n: 4'd10, bytes: 80'h0807060504030201_0008,  nw: 3'd4, words: 64'h0807_0605_0403_0201, run: 1'b1, err: 1'b0};
    vecs[6] = '{n: 4'd3,  bytes: 80'h5A_0001,                nw: 3'd1, words: 64'h005A,                run: 1'b1, err: 1'b0};
    vecs[7] = '{n: 4'd2,  bytes: 80'h0100,                   nw: 3'd0, words: 64'h0,                   run: 1'b0, err: 1'b1};
    vecs[8] = '{n: 4'd4,  bytes: 80'h4433_0002,              nw: 3'd1, words: 64'h4433,                run: 1'b1, err: 1'b0};

    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; reboot = 1'b0;
    repeat (3) tick();
    check("rst_mem_we",    64'(mem_we),    64'd0);
    check("rst_cpu_run",   64'(cpu_run),   64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_error",     64'(error),     64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b0;

    // Idle in LEN_LO must not time out.
    repeat (60) tick();
    check("lenlo_no_timeout", 64'(error), 64'd0);

    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      for (int k = 0; k < int'(v.nw); k++) expect_wr(2'(k), v.words[16*k +: 16]);
      for (int k = 0; k < int'(v.n); k++) begin
        send_byte(v.bytes[8*k +: 8]);
        tick();
      end
      repeat (3) tick();
      check($sformatf("vec%0d_cpu_run", i), 64'(cpu_run), 64'(v.run));
      check($sformatf("vec%0d_error", i),   64'(error),   64'(v.err));
      check($sformatf("vec%0d_writes", i),  64'(exp_q.size()), 64'd0);
      if (v.run) do_reboot();
      else check($sformatf("vec%0d_idle", i), 64'(busy), 64'd0);
    end

    // Write latency for complete words; reboot outside RUN is ignored.
    expect_wr(2'd0, 16'h0201);
    expect_wr(2'd1, 16'h0403);
    send_byte(8'h04);
    send_byte(8'h00);
    reboot = 1'b1;
    send_byte(8'h01);
    reboot = 1'b0;
    check("lat_no_early_we", 64'(mem_we), 64'd0);
    send_byte(8'h02);
    check("lat_we_word0", 64'(mem_we), 64'd1);
    tick();
    check("lat_we_single", 64'(mem_we), 64'd0);
    send_byte(8'h03);
    send_byte(8'h04);
    check("lat_we_word1", 64'(mem_we), 64'd1);
    check("lat_run_not_yet", 64'(cpu_run), 64'd0);
    tick();
    check("lat_run_after_write", 64'(cpu_run), 64'd1);
    check("lat_error", 64'(error), 64'd0);
    // Bytes in RUN are ignored.
    send_byte(8'hEE);
    tick();
    check("run_ignores_rx", 64'(cpu_run), 64'd1);
    do_reboot();

    // Flush timing; a byte during FLUSH is dropped.
    expect_wr(2'd0, 16'hBBAA);
    expect_wr(2'd1, 16'h00CC);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    check("flush_we", 64'(mem_we), 64'd1);
    check("flush_busy", 64'(busy), 64'd1);
    check("flush_run_low", 64'(cpu_run), 64'd0);
    send_byte(8'hDD);
    check("flush_run_high", 64'(cpu_run), 64'd1);
    repeat (2) tick();
    check("flush_writes", 64'(exp_q.size()), 64'd0);
    do_reboot();

    // Zero length releases the CPU right after the header.
    send_byte(8'h00);
    send_byte(8'h00);
    check("len0_run", 64'(cpu_run), 64'd1);
    do_reboot();

    // Timeout after 50 idle clocks with a partial word pending.
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    repeat (49) tick();
    check("tmo_not_yet", 64'(error), 64'd0);
    check("tmo_still_busy", 64'(busy), 64'd1);
    tick();
    check("tmo_error", 64'(error), 64'd1);
    check("tmo_idle", 64'(busy), 64'd0);
    expect_wr(2'd0, 16'h0077);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h77);
    repeat (3) tick();
    check("tmo_reload_run", 64'(cpu_run), 64'd1);
    check("tmo_reload_error", 64'(error), 64'd0);
    check("tmo_reload_writes", 64'(exp_q.size()), 64'd0);
    do_reboot();

    // A byte on the expiry cycle is accepted.
    expect_wr(2'd0, 16'h2211);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    repeat (49) tick();
    send_byte(8'h22);
    check("tmo_edge_we", 64'(mem_we), 64'd1);
    check("tmo_edge_error", 64'(error), 64'd0);
    tick();
    check("tmo_edge_run", 64'(cpu_run), 64'd1);
    do_reboot();

    // Reset mid-load: only the first word gets written.
    expect_wr(2'd0, 16'h0201);
    send_byte(8'h06);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    reset = 1'b1;
    rx_data = 8'h04; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    check("rst_mid_run", 64'(cpu_run), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_writes", 64'(exp_q.size()), 64'd0);
    expect_wr(2'd0, 16'h0099);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h99);
    repeat (3) tick();
    check("rst_reload_run", 64'(cpu_run), 64'd1);
    check("final_writes", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reflet_uart_boot_sequencer.md
Name: reflet_uart_boot_sequencer

Overview:
- Sequences program loading for the 16-bit controller at power-up.
- Takes a length-prefixed byte stream from the UART receiver and packs it into wordsize-bit words. Writes the words into instruction RAM from address 0, then releases the CPU.
- Sits between the UART RX core, the instruction RAM write port and the CPU run/hold control. Supports a timeout abort and a reboot request.

Parameters:
- wordsize, 16: RAM word width in bits; must be a multiple of 8, range 8..64. Bytes per word: bpw = wordsize/8.
- addr_width, 10: RAM word-address width. Capacity: max_bytes = 2^addr_width * bpw.
- timeout_cycles, 100000: maximum idle clocks between bytes once a load has started.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- rx_data, input, 8: received byte; valid only when rx_valid is 1.
- rx_valid, input, 1: single-cycle strobe, one per byte; no backpressure.
- reboot, input, 1: request to reload; honoured only in RUN.
- mem_addr, output, addr_width: RAM word address.
- mem_wdata, output, wordsize: RAM write data.
- mem_we, output, 1: RAM write enable, one cycle per word.
- cpu_run, output, 1: 1 = CPU released; 0 = CPU held in reset.
- busy, output, 1: 1 while in LEN_HI, DATA or FLUSH.
- error, output, 1: sticky load-failure flag.

Behaviour:
- States: LEN_LO, LEN_HI, DATA, FLUSH, RUN.
- Reset (takes priority over everything):
  - state=LEN_LO.
  - All outputs 0; error=0.
  - Byte counter, word address, pack register and timeout counter cleared.
- LEN_LO: on rx_valid, len[7:0]=rx_data, go to LEN_HI. Timeout is not armed.
- LEN_HI: on rx_valid, len[15:8]=rx_data, then:
  - len==0: go to RUN.
  - len>max_bytes: set error, go to LEN_LO.
  - otherwise: go to DATA.
- DATA:
  - Each rx_valid places the byte into byte lane (n mod bpw) of the pack register, little-endian (first byte lands in bits [7:0]).
  - When the lane bpw-1 byte arrives, the word is written in the next cycle: mem_we=1, mem_addr=word index, mem_wdata=packed word. The pack register then clears and the word index increments.
  - After the byte numbered len arrives:
    - Complete word: write it next cycle, and go to RUN in the same transition.
    - Partial word: go to FLUSH. FLUSH writes the word with unfilled upper lanes 0 (mem_we=1 for one cycle), then goes to RUN.
- Write latency: mem_we is high exactly one cycle after the rx_valid that completes a word, or on the FLUSH cycle. mem_we is 0 at all other times.
- RUN:
  - cpu_run=1, asserted in the cycle after the final write (or after LEN_HI when len==0).
  - error clears on entering RUN.
  - rx_valid is ignored.
- reboot in RUN: next cycle cpu_run=0, state=LEN_LO, counters cleared, RAM contents untouched. reboot outside RUN is ignored.
- Timeout:
  - In LEN_HI and DATA, a counter counts clocks since the last rx_valid.
  - When it reaches timeout_cycles: set error, discard the partial word (no write), clear counters, go to LEN_LO.
  - rx_valid in the expiry cycle wins: the byte is accepted and the counter resets.
- rx_valid during FLUSH is dropped.
- Reset mid-load: no further writes occur, cpu_run stays 0, loading restarts from LEN_LO.
- Width rules:
  - Byte counter is 16 bits.
  - Word index is addr_width bits; it never wraps, because len≤max_bytes is checked.
  - Timeout counter is $clog2(timeout_cycles+1) bits.

Test Plan:
- wordsize=16. Stream 04 00 01 02 03 04 -> writes addr0=0x0201 and addr1=0x0403, each a one-cycle mem_we one clock after byte 02/04. cpu_run rises the cycle after the second write; error=0.
- Stream 03 00 AA BB CC -> addr0=0xBBAA, then FLUSH writes addr1=0x00CC. cpu_run=1 one cycle after the FLUSH write.
- Stream 00 00 -> no mem_we pulses; cpu_run=1 the cycle after the second header byte.
- addr_width=2 (max 8 bytes). Stream 09 00 -> error=1, state back to LEN_LO, no writes. A following 02 00 11 22 writes addr0=0x2211, cpu_run=1, error=0.
- timeout_cycles=50. Stream 02 00 11, then silence -> at 50 idle clocks error=1, no write occurs, and a fresh header is accepted. Second case: a byte landing exactly on the expiry cycle is accepted and no error is raised.
- After a completed load, pulse reboot -> cpu_run=0 next cycle, and a new stream 02 00 33 44 overwrites addr0=0x4433. Separately, asserting reset after 3 data bytes -> no further mem_we and cpu_run=0.
